// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory interface.
//
// One transaction is in flight at a time, and the grant is held until that
// transaction completes. A watchdog force-completes a transaction when the
// slave does not answer within TIMEOUT cycles.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   m0_* / m1_*             master ports (valid/ready/addr/wdata/wstrb/rdata)
//   s_*                     shared slave port towards the SoC address decode
//   grant                   current owner, or the last owner while idle (0 = m0)
//   timeout_err             sticky flag, set when a watchdog timeout occurs
//   err_master              owner of the most recent timed-out transaction
//   err_clr                 clears timeout_err; a timeout in the same cycle wins
module picosoc_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic        grant,
  output logic        timeout_err,
  output logic        err_master,
  input  logic        err_clr
);

  localparam bit          WdogEn  = (TIMEOUT != 0);
  // Counter value seen in the last BUSY cycle the slave is allowed.
  localparam logic [15:0] CntLast = WdogEn ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_q, prio_d;      // 0 favours m0, 1 favours m1
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        err_master_q, err_master_d;

  logic        done;
  logic [31:0] rsp_data;

  // Payload mux follows the registered grant only.
  assign s_addr  = grant_q ? m1_addr  : m0_addr;
  assign s_wdata = grant_q ? m1_wdata : m0_wdata;
  assign s_wstrb = grant_q ? m1_wstrb : m0_wstrb;

  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;
  assign err_master  = err_master_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q & ~err_clr;
    err_master_d  = err_master_q;
    s_valid       = 1'b0;
    done          = 1'b0;
    rsp_data      = s_rdata;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_valid && m1_valid) begin
          grant_d = prio_q;
          state_d = StBusy;
        end else if (m0_valid) begin
          grant_d = 1'b0;
          state_d = StBusy;
        end else if (m1_valid) begin
          grant_d = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        s_valid = 1'b1;
        if (s_ready) begin
          // A real response in the last allowed cycle beats the watchdog.
          done = 1'b1;
        end else if (WdogEn && (cnt_q == CntLast)) begin
          done          = 1'b1;
          rsp_data      = ERR_RDATA;
          timeout_err_d = 1'b1;
          err_master_d  = grant_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (done) begin
          state_d = StIdle;
          prio_d  = ~grant_q;
        end
      end
    endcase
  end

  // Ready and read data towards the masters; suppressed while reset is held
  // so an abandoned transaction never produces a completion pulse.
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (done && !reset) begin
      if (grant_q) begin
        m1_ready = 1'b1;
        m1_rdata = rsp_data;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      err_master_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      err_master_q  <= err_master_d;
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
module tb_picosoc_bus_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        grant, timeout_err, err_master, err_clr;

  picosoc_bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout_err(timeout_err),
    .err_master (err_master),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_cnt0 = 0;
  int rdy_cnt1 = 0;

  // Reference model state: transaction-level view of the arbiter.
  bit exp_grant, exp_ptr, exp_err, exp_em;

  always @(negedge clk) begin
    if (m0_ready) rdy_cnt0++;
    if (m1_ready) rdy_cnt1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b0;
    err_clr  = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b0;
    exp_grant = 1'b0;
    exp_ptr   = 1'b0;
    exp_err   = 1'b0;
    exp_em    = 1'b0;
  endtask

  task automatic set_payload(input bit m, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    if (m) begin
      m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
  endtask

  // One transaction owned by 'own'; the slave stalls 'lat' BUSY cycles and then
  // answers (lat >= TO means the watchdog fires first). Entered at posedge+1
  // with the requesting valid(s) already raised and the arbiter idle.
  task automatic do_txn(input bit own, input int lat, input logic [31:0] sdat, input bit clr);
    bit          done;
    bit          normal;
    logic [31:0] exp_rd;
    @(negedge clk);
    chk1("idle_s_valid", s_valid, 1'b0);
    chk1("idle_grant", grant, exp_grant);
    @(posedge clk); #1;
    exp_grant = own;
    for (int k = 1; k <= int'(TO); k++) begin
      normal  = (k == lat + 1);
      done    = normal || (k == int'(TO));
      s_ready = normal;
      s_rdata = sdat;
      err_clr = clr && done;
      exp_rd  = normal ? sdat : ERR;
      @(negedge clk);
      chk1("busy_s_valid", s_valid, 1'b1);
      chk1("busy_grant", grant, own);
      chk32("s_addr", s_addr, own ? m1_addr : m0_addr);
      chk32("s_wdata", s_wdata, own ? m1_wdata : m0_wdata);
      chk32("s_wstrb", {28'd0, s_wstrb}, {28'd0, own ? m1_wstrb : m0_wstrb});
      chk1("owner_ready", own ? m1_ready : m0_ready, done);
      chk32("owner_rdata", own ? m1_rdata : m0_rdata, done ? exp_rd : 32'd0);
      chk1("other_ready", own ? m0_ready : m1_ready, 1'b0);
      chk32("other_rdata", own ? m0_rdata : m1_rdata, 32'd0);
      @(posedge clk); #1;
      s_ready = 1'b0;
      err_clr = 1'b0;
      if (done) begin
        if (clr) exp_err = 1'b0;
        if (!normal) begin
          exp_err = 1'b1;
          exp_em  = own;
        end
        exp_ptr = ~own;
        if (own) m1_valid = 1'b0; else m0_valid = 1'b0;
        break;
      end
    end
    chk1("timeout_err", timeout_err, exp_err);
    chk1("err_master", err_master, exp_em);
  endtask

  initial begin
    int  c0, c1, mode, lat;
    bit  first;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata = '0;
    do_reset();
    @(negedge clk);
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk32("rst_m0_rdata", m0_rdata, 32'd0);
    chk32("rst_m1_rdata", m1_rdata, 32'd0);
    chk1("rst_grant", grant, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chk1("rst_err_master", err_master, 1'b0);
    @(posedge clk); #1;

    // Single m0 read, slave answers two cycles after s_valid rises.
    set_payload(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    m0_valid = 1'b1;
    do_txn(1'b0, 2, 32'h1234_5678, 1'b0);

    // Continuous contention from reset: m0, m1, m0, m1.
    do_reset();
    set_payload(1'b0, 32'h0000_0100, 32'h1111_0000, 4'hF);
    set_payload(1'b1, 32'h0000_0200, 32'h2222_0000, 4'h3);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    c0 = rdy_cnt0;
    c1 = rdy_cnt1;
    for (int i = 0; i < 4; i++) begin
      chk1("rr_order", exp_ptr, i[0]);
      first = exp_ptr;
      do_txn(first, 0, $urandom, 1'b0);
      if (i < 2) begin
        if (first) m1_valid = 1'b1; else m0_valid = 1'b1;
      end
    end
    chk32("rr_m0_pulses", rdy_cnt0 - c0, 32'd2);
    chk32("rr_m1_pulses", rdy_cnt1 - c1, 32'd2);

    // m1 write with m0 idle.
    set_payload(1'b1, 32'h0200_0008, 32'h0000_0041, 4'b0001);
    m1_valid = 1'b1;
    c0 = rdy_cnt0;
    do_txn(1'b1, 1, 32'h0, 1'b0);
    chk32("wr_m0_pulses", rdy_cnt0 - c0, 32'd0);

    // Slave never answers: watchdog completion, then clear the flag.
    set_payload(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    m0_valid = 1'b1;
    do_txn(1'b0, 1000, 32'h0, 1'b0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk1("err_clr", timeout_err, 1'b0);

    // Response in the last allowed cycle beats the watchdog.
    m0_valid = 1'b1;
    do_txn(1'b0, int'(TO) - 1, 32'hCAFE_0001, 1'b0);

    // Timeout coinciding with err_clr: the set wins.
    m1_valid = 1'b1;
    do_txn(1'b1, 1000, 32'h0, 1'b1);

    // Reset in the second BUSY cycle of an m1 transaction.
    set_payload(1'b1, 32'h0000_0300, 32'h0, 4'h0);
    m1_valid = 1'b1;
    c0 = rdy_cnt0;
    c1 = rdy_cnt1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    exp_grant = 1'b0;
    exp_ptr   = 1'b0;
    exp_err   = 1'b0;
    exp_em    = 1'b0;
    chk1("rst_mid_s_valid", s_valid, 1'b0);
    chk1("rst_mid_grant", grant, 1'b0);
    chk1("rst_mid_err", timeout_err, 1'b0);
    chk32("rst_mid_pulses", (rdy_cnt0 - c0) + (rdy_cnt1 - c1), 32'd0);
    m0_valid = 1'b1;
    do_txn(1'b0, 0, 32'hA5A5_0000, 1'b0);
    do_txn(1'b1, 0, 32'h5A5A_0000, 1'b0);

    // Randomised traffic against the transaction-level model.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      set_payload(1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      set_payload(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (mode == 0) begin
        m0_valid = 1'b1;
        do_txn(1'b0, $urandom_range(0, 9), $urandom, ($urandom_range(0, 3) == 0));
      end else if (mode == 1) begin
        m1_valid = 1'b1;
        do_txn(1'b1, $urandom_range(0, 9), $urandom, ($urandom_range(0, 3) == 0));
      end else begin
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        first = exp_ptr;
        lat = $urandom_range(0, 9);
        do_txn(first, lat, $urandom, ($urandom_range(0, 3) == 0));
        do_txn(~first, $urandom_range(0, 9), $urandom, ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 4) == 0) begin
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk1("rnd_err_clr", timeout_err, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
